// File: rtl/matmul_pkg.sv
// Shared definitions for the sequential matrix multiplier: FSM state codes,
// read-port select codes, default parameter values and a dimension check helper.
package matmul_pkg;

  localparam int DW_DEF     = 20;
  localparam int IW_DEF     = 20;
  localparam int ACCW_DEF   = 48;
  localparam int MAXDIM_DEF = 1024;

  typedef logic [3:0] state_t;

  localparam state_t ST_IDLE = 4'd0;
  localparam state_t ST_HDR  = 4'd1;
  localparam state_t ST_CHK  = 4'd2;
  localparam state_t ST_RDA  = 4'd3;
  localparam state_t ST_RDB  = 4'd4;
  localparam state_t ST_MAC  = 4'd5;
  localparam state_t ST_WR   = 4'd6;
  localparam state_t ST_NEXT = 4'd7;
  localparam state_t ST_DONE = 4'd8;
  localparam state_t ST_ERR  = 4'd9;

  localparam logic [1:0] HDR_SEL = 2'd0;
  localparam logic [1:0] A_SEL   = 2'd1;
  localparam logic [1:0] B_SEL   = 2'd2;

  // A dimension is usable only when it is non-zero and within the legal maximum.
  function automatic logic dim_bad(input logic [31:0] d, input logic [31:0] max_d);
    return (d == 32'd0) || (d > max_d);
  endfunction

endpackage

// File: rtl/matmul_mac.sv
// Signed/unsigned multiply-accumulate for one C element.
// Latency: product added on the edge where en is high; no backpressure (clr has priority over en).
module matmul_mac import matmul_pkg::*; #(
  parameter int DW   = DW_DEF,
  parameter int ACCW = ACCW_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            signed_mode,
  input  logic            clr,
  input  logic            en,
  input  logic [DW-1:0]   a,
  input  logic [DW-1:0]   b,
  output logic [ACCW-1:0] acc
);

  logic signed [DW:0]     a_ext;
  logic signed [DW:0]     b_ext;
  logic signed [2*DW+1:0] prod;

  // One extra bit lets a single signed multiplier serve both modes: unsigned
  // operands get a zero top bit, signed ones a copy of their sign.
  assign a_ext = signed_mode ? {a[DW-1], a} : {1'b0, a};
  assign b_ext = signed_mode ? {b[DW-1], b} : {1'b0, b};
  assign prod  = a_ext * b_ext;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc + ACCW'(prod);
    end
  end

endmodule

// File: rtl/matmul_seq.sv
// Sequential C = A*B engine: reads header and operands one word at a time, writes C row-major.
// Latency: 5 + R*C2*(3K+2) cycles with zero-wait memory; reads stall on rd_valid, writes on wr_ready.
module matmul_seq import matmul_pkg::*; #(
  parameter int DW     = DW_DEF,
  parameter int IW     = IW_DEF,
  parameter int ACCW   = ACCW_DEF,
  parameter int MAXDIM = MAXDIM_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            signed_mode,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic            rd_en,
  output logic [1:0]      rd_sel,
  output logic [IW-1:0]   rd_i,
  output logic [IW-1:0]   rd_j,
  input  logic [DW-1:0]   rd_data,
  input  logic            rd_valid,
  output logic            wr_en,
  output logic [IW-1:0]   wr_i,
  output logic [IW-1:0]   wr_j,
  output logic [ACCW-1:0] wr_data,
  input  logic            wr_ready
);

  localparam logic [DW-1:0] ONE = DW'(1);

  state_t          state;
  logic            sgn;
  logic [1:0]      hdr_cnt;
  logic [DW-1:0]   r_dim;
  logic [DW-1:0]   k_dim;
  logic [DW-1:0]   c_dim;
  logic [DW-1:0]   m;
  logic [DW-1:0]   k;
  logic [DW-1:0]   n;
  logic [DW-1:0]   a_op;
  logic [DW-1:0]   b_op;
  logic [ACCW-1:0] acc;
  logic            mac_clr;
  logic            mac_en;
  logic            dims_bad;

  assign dims_bad = dim_bad(32'(r_dim), 32'(MAXDIM)) ||
                    dim_bad(32'(k_dim), 32'(MAXDIM)) ||
                    dim_bad(32'(c_dim), 32'(MAXDIM));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      sgn     <= 1'b0;
      hdr_cnt <= 2'd0;
      r_dim   <= '0;
      k_dim   <= '0;
      c_dim   <= '0;
      m       <= '0;
      k       <= '0;
      n       <= '0;
      a_op    <= '0;
      b_op    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            sgn     <= signed_mode;
            hdr_cnt <= 2'd0;
            m       <= '0;
            k       <= '0;
            n       <= '0;
            state   <= ST_HDR;
          end
        end
        ST_HDR: begin
          if (rd_valid) begin
            case (hdr_cnt)
              2'd0:    r_dim <= rd_data;
              2'd1:    k_dim <= rd_data;
              default: c_dim <= rd_data;
            endcase
            hdr_cnt <= hdr_cnt + 2'd1;
            if (hdr_cnt == 2'd2) begin
              state <= ST_CHK;
            end
          end
        end
        ST_CHK: begin
          state <= dims_bad ? ST_ERR : ST_RDA;
        end
        ST_RDA: begin
          if (rd_valid) begin
            a_op  <= rd_data;
            state <= ST_RDB;
          end
        end
        ST_RDB: begin
          if (rd_valid) begin
            b_op  <= rd_data;
            state <= ST_MAC;
          end
        end
        ST_MAC: begin
          if (n == k_dim - ONE) begin
            state <= ST_WR;
          end else begin
            n     <= n + ONE;
            state <= ST_RDA;
          end
        end
        ST_WR: begin
          if (wr_ready) begin
            state <= ST_NEXT;
          end
        end
        ST_NEXT: begin
          n <= '0;
          if (k == c_dim - ONE) begin
            k <= '0;
            if (m == r_dim - ONE) begin
              state <= ST_DONE;
            end else begin
              m     <= m + ONE;
              state <= ST_RDA;
            end
          end else begin
            k     <= k + ONE;
            state <= ST_RDA;
          end
        end
        ST_DONE: state <= ST_IDLE;
        ST_ERR:  state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Accumulator is cleared both when a new operation starts and between C elements.
  assign mac_clr = ((state == ST_IDLE) && start) || (state == ST_NEXT);
  assign mac_en  = (state == ST_MAC);

  matmul_mac #(
    .DW   (DW),
    .ACCW (ACCW)
  ) u_mac (
    .clk         (clk),
    .reset       (reset),
    .signed_mode (sgn),
    .clr         (mac_clr),
    .en          (mac_en),
    .a           (a_op),
    .b           (b_op),
    .acc         (acc)
  );

  // Request fields are pure functions of state and indices, so they hold
  // unchanged for as long as the handshake stalls.
  always_comb begin
    rd_en  = 1'b0;
    rd_sel = HDR_SEL;
    rd_i   = '0;
    rd_j   = '0;
    case (state)
      ST_HDR: begin
        rd_en  = 1'b1;
        rd_sel = HDR_SEL;
        rd_i   = IW'(hdr_cnt);
      end
      ST_RDA: begin
        rd_en  = 1'b1;
        rd_sel = A_SEL;
        rd_i   = IW'(m);
        rd_j   = IW'(n);
      end
      ST_RDB: begin
        rd_en  = 1'b1;
        rd_sel = B_SEL;
        rd_i   = IW'(n);
        rd_j   = IW'(k);
      end
      default: begin
        rd_en = 1'b0;
      end
    endcase
  end

  assign wr_en   = (state == ST_WR);
  assign wr_i    = wr_en ? IW'(m) : '0;
  assign wr_j    = wr_en ? IW'(k) : '0;
  assign wr_data = wr_en ? acc : '0;

  assign busy = (state != ST_IDLE);
  assign done = (state == ST_DONE);
  assign err  = (state == ST_ERR);

endmodule

// File: tb/tb_matmul_seq.sv
// Directed bench for matmul_seq: memory/writer responders, a plain-arithmetic reference
// model feeding an expected-write queue, and one per-cycle compare process.
module tb_matmul_seq;

  localparam int DW     = 20;
  localparam int IW     = 20;
  localparam int ACCW   = 48;
  localparam int MAXDIM = 1024;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            start = 1'b0;
  logic            signed_mode = 1'b0;
  logic            busy, done, err, rd_en, wr_en;
  logic [1:0]      rd_sel;
  logic [IW-1:0]   rd_i, rd_j, wr_i, wr_j;
  logic [DW-1:0]   rd_data = '0;
  logic            rd_valid = 1'b0;
  logic [ACCW-1:0] wr_data;
  logic            wr_ready = 1'b0;

  matmul_seq #(.DW(DW), .IW(IW), .ACCW(ACCW), .MAXDIM(MAXDIM)) dut (
    .clk(clk), .reset(reset), .start(start), .signed_mode(signed_mode),
    .busy(busy), .done(done), .err(err),
    .rd_en(rd_en), .rd_sel(rd_sel), .rd_i(rd_i), .rd_j(rd_j),
    .rd_data(rd_data), .rd_valid(rd_valid),
    .wr_en(wr_en), .wr_i(wr_i), .wr_j(wr_j), .wr_data(wr_data), .wr_ready(wr_ready)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] hdr  [0:7];
  logic [DW-1:0] amem [0:7][0:7];
  logic [DW-1:0] bmem [0:7][0:7];

  typedef struct {
    int              i;
    int              j;
    logic [ACCW-1:0] d;
  } wr_t;
  wr_t exp_q[$];

  int n_checks = 0, n_pass = 0;
  int rd_dly_max = 0, rd_wait = 0, wr_mode = 0, wr_stall = 0;
  int cyc = 0, s0 = 0, done_cyc = 0, done_cnt = 0, err_cnt = 0, n_writes = 0;
  bit op_done = 0, op_err = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, req);
  endtask

  function automatic logic [DW-1:0] mem_rd(input logic [1:0] s, input logic [IW-1:0] i,
                                           input logic [IW-1:0] j);
    if (i >= 8 || j >= 8) return '0;
    case (s)
      2'd0:    return hdr[i[2:0]];
      2'd1:    return amem[i[2:0]][j[2:0]];
      2'd2:    return bmem[i[2:0]][j[2:0]];
      default: return '0;
    endcase
  endfunction

  function automatic longint opv(input bit sgn, input logic [DW-1:0] v);
    return sgn ? longint'(signed'(v)) : longint'(v);
  endfunction

  // Reference: C[m][k] = sum_n A[m][n]*B[n][k], kept modulo 2^ACCW, row-major order.
  task automatic build_exp(input bit sgn, input int r, input int kd, input int c2);
    exp_q.delete();
    for (int mi = 0; mi < r; mi++) begin
      for (int kj = 0; kj < c2; kj++) begin
        longint s;
        wr_t e;
        s = 0;
        for (int ni = 0; ni < kd; ni++) s += opv(sgn, amem[mi][ni]) * opv(sgn, bmem[ni][kj]);
        e.i = mi; e.j = kj; e.d = ACCW'(s);
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic set_hdr(input int r, input int kd, input int c2);
    hdr[0] = DW'(r); hdr[1] = DW'(kd); hdr[2] = DW'(c2);
  endtask

  task automatic load_2x2();
    set_hdr(2, 2, 2);
    amem[0][0] = DW'(1); amem[0][1] = DW'(-2); amem[1][0] = DW'(3);  amem[1][1] = DW'(4);
    bmem[0][0] = DW'(5); bmem[0][1] = DW'(6);  bmem[1][0] = DW'(-7); bmem[1][1] = DW'(8);
  endtask

  task automatic check_reset_vals(input string nm);
    chk({nm, "_ctrl"}, 128'({busy, done, err, rd_en, wr_en, rd_sel}), 128'(0));
    chk({nm, "_idx"},  128'({rd_i, rd_j, wr_i, wr_j}), 128'(0));
    chk({nm, "_wdat"}, 128'(wr_data), 128'(0));
  endtask

  // Read responder: waits rd_wait cycles per request, then returns data combinationally.
  always @(negedge clk) begin
    if (rd_valid) rd_wait = int'($urandom_range(rd_dly_max, 0));
    if (reset || !rd_en) begin
      rd_valid = 1'b0;
    end else if (rd_wait > 0) begin
      rd_wait--;
      rd_valid = 1'b0;
    end else begin
      rd_valid = 1'b1;
      rd_data  = mem_rd(rd_sel, rd_i, rd_j);
    end
  end

  // Write acceptor: mode 0 always ready, 1 random stalls, 2 two stall cycles per write.
  always @(negedge clk) begin
    if (reset || !wr_en) begin
      wr_stall = 0;
      wr_ready = (wr_mode == 0);
    end else begin
      case (wr_mode)
        0:       wr_ready = 1'b1;
        1:       wr_ready = ($urandom_range(2, 0) != 0);
        default: begin wr_ready = (wr_stall >= 2); wr_stall++; end
      endcase
    end
  end

  logic         prev_rd_stall = 0, prev_wr_stall = 0;
  logic [127:0] prev_rd_b = '0, prev_wr_b = '0;

  always @(negedge clk) begin
    #4;
    if (reset) begin
      prev_rd_stall = 0;
      prev_wr_stall = 0;
    end else begin
      cyc++;
      chk("rd_wr_exclusive", 128'(rd_en & wr_en), 128'(0));
      if (prev_rd_stall) chk("rd_hold", 128'({rd_en, rd_sel, rd_i, rd_j}), prev_rd_b);
      if (prev_wr_stall) chk("wr_hold", 128'({wr_en, wr_i, wr_j, wr_data}), prev_wr_b);
      prev_rd_stall = rd_en && !rd_valid;
      prev_rd_b     = 128'({rd_en, rd_sel, rd_i, rd_j});
      prev_wr_stall = wr_en && !wr_ready;
      prev_wr_b     = 128'({wr_en, wr_i, wr_j, wr_data});
      if (start && !busy) s0 = cyc;
      if (done) begin done_cnt++; op_done = 1; done_cyc = cyc - s0; end
      if (err) begin err_cnt++; op_err = 1; end
      if (wr_en && wr_ready) begin
        n_writes++;
        chk("write_expected", 128'(exp_q.size() > 0), 128'(1));
        if (exp_q.size() > 0) begin
          wr_t e;
          e = exp_q.pop_front();
          chk("wr_i", 128'(wr_i), 128'(e.i));
          chk("wr_j", 128'(wr_j), 128'(e.j));
          chk("wr_data", 128'(wr_data), 128'(e.d));
        end
      end
    end
  end

  task automatic run_op(input logic sgn, input bit noisy, input int budget);
    int n;
    n = 0;
    op_done = 0; op_err = 0;
    @(negedge clk); #3; signed_mode = sgn; start = 1'b1;
    @(negedge clk); #3; start = 1'b0;
    chk("busy_after_start", 128'(busy), 128'(1));
    while (!(op_done || op_err) && n < budget) begin
      @(negedge clk); #3;
      if (noisy) begin
        start       = (n % 4 == 1);
        signed_mode = ~sgn;
      end
      n++;
    end
    start = 1'b0;
    signed_mode = sgn;
    chk("op_finished", 128'(op_done || op_err), 128'(1));
  endtask

  task automatic err_case(input string nm, input int r, input int kd, input int c2);
    int ec0, nw0, dc0;
    set_hdr(r, kd, c2);
    exp_q.delete();
    ec0 = err_cnt; nw0 = n_writes; dc0 = done_cnt;
    run_op(1'b0, 1'b0, 100);
    repeat (3) @(negedge clk);
    #3;
    chk({nm, "_err_once"}, 128'(err_cnt - ec0), 128'(1));
    chk({nm, "_no_writes"}, 128'(n_writes - nw0), 128'(0));
    chk({nm, "_no_done"}, 128'(done_cnt - dc0), 128'(0));
    chk({nm, "_idle"}, 128'(busy), 128'(0));
  endtask

  initial begin
    int nw0, dc0, n;
    repeat (3) @(negedge clk);
    #3;
    check_reset_vals("reset_state");
    reset = 1'b0;

    // 2x2x2 signed, zero-wait memory.
    load_2x2();
    build_exp(1'b1, 2, 2, 2);
    chk("model_c00", 128'(exp_q[0].d), 128'(48'd19));
    chk("model_c01", 128'(exp_q[1].d), 128'(48'hFFFF_FFFF_FFF6));
    chk("model_c10", 128'(exp_q[2].d), 128'(48'hFFFF_FFFF_FFF3));
    chk("model_c11", 128'(exp_q[3].d), 128'(48'd50));
    rd_dly_max = 0; rd_wait = 0; wr_mode = 0;
    nw0 = n_writes;
    run_op(1'b1, 1'b0, 2000);
    chk("done_cycle_2x2x2", 128'(done_cyc), 128'(37));
    chk("writes_2x2x2", 128'(n_writes - nw0), 128'(4));
    chk("queue_empty_2x2x2", 128'(exp_q.size()), 128'(0));

    // 1x1x1 unsigned, full-scale operands.
    set_hdr(1, 1, 1);
    amem[0][0] = DW'(20'hFFFFF); bmem[0][0] = DW'(20'hFFFFF);
    build_exp(1'b0, 1, 1, 1);
    chk("model_1x1x1", 128'(exp_q[0].d), 128'(48'h00FF_FFE0_0001));
    nw0 = n_writes;
    run_op(1'b0, 1'b0, 500);
    chk("writes_1x1x1", 128'(n_writes - nw0), 128'(1));
    chk("done_cycle_1x1x1", 128'(done_cyc), 128'(10));

    // 3x4x2 signed, random read delays and write stalls, start/mode noise while busy.
    set_hdr(3, 4, 2);
    for (int mi = 0; mi < 3; mi++)
      for (int ni = 0; ni < 4; ni++) amem[mi][ni] = DW'(mi * 4 + ni - 5);
    for (int ni = 0; ni < 4; ni++) begin
      bmem[ni][0] = DW'((ni + 1) * 3);
      bmem[ni][1] = DW'(2 - ni * 7);
    end
    build_exp(1'b1, 3, 4, 2);
    chk("model_3x4x2_c00", 128'(exp_q[0].d), 128'(48'hFFFF_FFFF_FFA6));
    chk("model_3x4x2_c01", 128'(exp_q[1].d), 128'(48'd84));
    rd_dly_max = 5; wr_mode = 1;
    nw0 = n_writes; dc0 = done_cnt;
    run_op(1'b1, 1'b1, 8000);
    repeat (5) @(negedge clk);
    #3;
    chk("writes_3x4x2", 128'(n_writes - nw0), 128'(6));
    chk("done_once_3x4x2", 128'(done_cnt - dc0), 128'(1));
    chk("queue_empty_3x4x2", 128'(exp_q.size()), 128'(0));

    // Header dimension errors.
    rd_dly_max = 0; rd_wait = 0; wr_mode = 0;
    err_case("hdr_k_zero", 2, 0, 2);
    err_case("hdr_r_over", MAXDIM + 1, 1, 1);

    // Reset during the stall of the third write, then a clean rerun.
    load_2x2();
    build_exp(1'b1, 2, 2, 2);
    wr_mode = 2;
    nw0 = n_writes;
    op_done = 0;
    @(negedge clk); #3; signed_mode = 1'b1; start = 1'b1;
    @(negedge clk); #3; start = 1'b0;
    n = 0;
    while (!((n_writes - nw0) == 2 && wr_en && !wr_ready) && n < 2000) begin
      @(negedge clk); #3;
      n++;
    end
    chk("reached_third_wr_stall", 128'((n_writes - nw0) == 2 && wr_en && !wr_ready), 128'(1));
    reset = 1'b1;
    #1;
    check_reset_vals("reset_mid_wr");
    repeat (2) @(negedge clk);
    #3;
    exp_q.delete();
    rd_wait = 0; wr_mode = 0;
    reset = 1'b0;
    build_exp(1'b1, 2, 2, 2);
    nw0 = n_writes;
    run_op(1'b1, 1'b0, 2000);
    chk("writes_after_reset", 128'(n_writes - nw0), 128'(4));
    chk("done_cycle_after_reset", 128'(done_cyc), 128'(37));
    repeat (3) @(negedge clk);
    #3;
    chk("done_total", 128'(done_cnt), 128'(4));
    chk("err_total", 128'(err_cnt), 128'(2));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, %0d/%0d checks passed so far", n_pass, n_checks);
    $fatal(1);
  end

endmodule

// File: doc/matmul_seq.md
MATMUL_SEQ -- requirements
Module: matmul_seq

Interface
REQ-001 Parameter DW, default 20, operand and dimension data width (bits).
REQ-002 Parameter IW, default 20, row/column index width on the memory ports.
REQ-003 Parameter ACCW, default 48, accumulator and result width; SHALL be >= 2*DW.
REQ-004 Parameter MAXDIM, default 1024, largest legal value of any dimension.
REQ-005 Port list, clock and reset first:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high.
- start  in  1  begin an operation; sampled only in IDLE.
- signed_mode  in  1  1 = two's-complement operands, 0 = unsigned; latched at start.
- busy  out  1  high from the cycle after start is accepted until DONE/ERR is left.
- done  out  1  one-cycle pulse on successful completion.
- err  out  1  one-cycle pulse on a dimension error.
- rd_en  out  1  read request.
- rd_sel  out  2  0 = header, 1 = matrix A, 2 = matrix B.
- rd_i  out  IW  row index; header word number when rd_sel = 0.
- rd_j  out  IW  column index.
- rd_data  in  DW  read data; valid when rd_valid is high.
- rd_valid  in  1  read completion; may assert in the same cycle as rd_en.
- wr_en  out  1  write request for C.
- wr_i  out  IW  C row index.
- wr_j  out  IW  C column index.
- wr_data  out  ACCW  C element.
- wr_ready  in  1  write accepted when high together with wr_en.

Function
REQ-006 The FSM SHALL have exactly these states: IDLE, HDR, CHK, RDA, RDB, MAC, WR, NEXT, DONE, ERR.
REQ-007 IDLE: on start = 1, latch signed_mode, clear all indices, and go to HDR.
REQ-008 HDR: read header words 0, 1, 2 (rd_sel = 0, rd_i = 0/1/2, rd_j = 0) into R, K, C2 in that order, then go to CHK.
REQ-009 CHK: if any of R, K, C2 is 0 or greater than MAXDIM, go to ERR; otherwise go to RDA. CHK takes one cycle.
REQ-010 Compute C = A(RxK) * B(KxC2):
- outer loop m (row), middle loop k (column of C), inner loop n, with n < K.
- C elements are produced in row-major order.
REQ-011 RDA reads A[m][n]; RDB reads B[n][k]; MAC adds the product to the accumulator; MAC returns to RDA while n < K-1, else goes to WR.
REQ-012 Read handshake:
- rd_en, rd_sel, rd_i and rd_j are held stable until rd_valid = 1.
- Data is captured in the cycle rd_valid = 1.
- At most one read is outstanding.
- rd_valid is ignored while rd_en = 0.
REQ-013 Write handshake: wr_en = 1 with wr_i = m, wr_j = k and wr_data = accumulator, all held until wr_ready = 1; then go to NEXT.
REQ-014 NEXT:
- clear the accumulator and n;
- advance k, wrapping to 0 and incrementing m;
- go to DONE after the last element, else to RDA.
REQ-015 DONE and ERR each last one cycle, pulse done or err respectively, then return to IDLE.
REQ-016 Arithmetic:
- product is the full 2*DW bits, sign- or zero-extended per the latched mode, then extended to ACCW;
- accumulation wraps modulo 2^ACCW with no saturation.
REQ-017 Timing with zero-wait memory and wr_ready = 1: start accepted at edge 0; done high in cycle 5 + R*C2*(3K+2).
REQ-018 start while not in IDLE SHALL be ignored, and changing signed_mode mid-operation SHALL have no effect.
REQ-019 A 1x1x1 operation SHALL produce exactly one write at (0,0).
REQ-020 rd_en and wr_en SHALL never be high in the same cycle.

Reset
REQ-021 Reset SHALL force the following within the same cycle, regardless of FSM state:
- state = IDLE;
- busy, done, err, rd_en, wr_en = 0;
- rd_sel, rd_i, rd_j, wr_i, wr_j, wr_data, accumulator, R, K, C2 = 0.
REQ-022 Reset mid-operation SHALL abandon any outstanding read or write; a rd_valid arriving after reset is released SHALL be ignored.

Structure
REQ-023 Package matmul_pkg SHALL hold:
- the state enumeration;
- the rd_sel codes HDR_SEL = 0, A_SEL = 1, B_SEL = 2;
- default values of DW, IW, ACCW and MAXDIM.
REQ-024 One sub-module, matmul_mac, SHALL contain the signed/unsigned multiplier and accumulator, with clear and enable inputs.

Verification
REQ-025 2x2x2 signed test, zero-wait memory:
- stimulus: A = [[1,-2],[3,4]], B = [[5,6],[-7,8]];
- required: writes (0,0) = 19, (0,1) = -10, (1,0) = -13, (1,1) = 50, in that order;
- required: done high in cycle 37.
REQ-026 Unsigned, DW = 20, 1x1x1 test:
- stimulus: A = B = 0xFFFFF;
- required: wr_data = 0xFFFFE00001, and exactly one write.
REQ-027 Random rd_valid delay of 0-5 cycles and random wr_ready stalls, 3x4x2 matrices:
- required: results match the reference model;
- required: request signals stay stable while stalled.
REQ-028 Header dimension checks:
- header K = 0 -> err pulses once, no writes, return to IDLE;
- header R = MAXDIM+1 -> same response.
REQ-029 Reset asserted during the third WR stall:
- required: all outputs at reset values immediately;
- required: a new start afterwards completes correctly.
REQ-030 start pulsed while busy -> ignored; done pulses exactly once per accepted start.
